// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions used by the keyboard transmitter and receiver.
package ps2_pkg;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HIGH,
    ST_LOW,
    ST_GAP
  } ps2_state_t;

  // Parity bit that makes data plus parity carry an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Byte FIFO for the PS/2 transmitter; pointers carry an extra wrap bit for full/empty.
module ps2_tx_fifo
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_push;
  logic        w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = i_pop && !o_empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: queues scan codes and sends 11-bit frames with
// registered clock/data lines, aborting and retrying when the host inhibits.
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int unsigned HALF = 50,
  parameter int unsigned GAP  = 200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       inhibit,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned CW = $clog2(((HALF > GAP) ? HALF : GAP) + 1);
  localparam int unsigned BW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_BITS - 1);

  function automatic logic frame_bit(input logic [7:0] b, input logic p, input logic [BW-1:0] idx);
    case (idx)
      BW'(0):  return 1'b0;
      BW'(9):  return p;
      BW'(10): return 1'b1;
      default: return b[3'(idx - 1'b1)];
    endcase
  endfunction

  ps2_state_t    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [BW-1:0] r_bit, w_bit_nxt;
  logic [7:0]    r_byte, w_byte_nxt;
  logic [7:0]    r_held, w_held_nxt;
  logic          r_held_vld, w_held_vld_nxt;
  logic          r_par, w_par_nxt;
  logic          r_ps2_clk, w_ps2_clk_nxt;
  logic          r_ps2_data, w_ps2_data_nxt;
  logic          r_done, w_done_nxt;
  logic          w_push, w_pop, w_full, w_empty;
  logic [7:0]    w_head, w_src_byte;

  assign in_ready   = !w_full;
  assign w_push     = in_valid && in_ready;
  assign ps2_clk    = r_ps2_clk;
  assign ps2_data   = r_ps2_data;
  assign frame_done = r_done;
  assign busy       = (r_state != ST_IDLE);

  ps2_tx_fifo u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // An aborted byte is parked in r_held and takes priority over the FIFO head,
  // so it is re-sent first without needing to push it back into the FIFO.
  assign w_src_byte = r_held_vld ? r_held : w_head;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt + 1'b1;
    w_bit_nxt      = r_bit;
    w_byte_nxt     = r_byte;
    w_par_nxt      = r_par;
    w_held_nxt     = r_held;
    w_held_vld_nxt = r_held_vld;
    w_ps2_clk_nxt  = r_ps2_clk;
    w_ps2_data_nxt = r_ps2_data;
    w_done_nxt     = 1'b0;
    w_pop          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt      = '0;
        w_ps2_clk_nxt  = 1'b1;
        w_ps2_data_nxt = 1'b1;
        if ((r_held_vld || !w_empty) && !inhibit) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_pop          = !r_held_vld;
        w_held_vld_nxt = 1'b0;
        w_byte_nxt     = w_src_byte;
        w_par_nxt      = odd_parity(w_src_byte);
        w_bit_nxt      = '0;
        w_cnt_nxt      = '0;
        w_ps2_clk_nxt  = 1'b1;
        w_ps2_data_nxt = 1'b0;
        w_state_nxt    = ST_HIGH;
      end
      ST_HIGH: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt     = '0;
          w_ps2_clk_nxt = 1'b0;
          w_state_nxt   = ST_LOW;
        end
      end
      ST_LOW: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt     = '0;
          w_ps2_clk_nxt = 1'b1;
          if (r_bit == LAST_BIT) begin
            w_ps2_data_nxt = 1'b1;
            w_done_nxt     = 1'b1;
            w_state_nxt    = ST_GAP;
          end else begin
            w_bit_nxt      = r_bit + 1'b1;
            w_ps2_data_nxt = frame_bit(r_byte, r_par, r_bit + 1'b1);
            w_state_nxt    = ST_HIGH;
          end
        end
      end
      ST_GAP: begin
        w_ps2_clk_nxt  = 1'b1;
        w_ps2_data_nxt = 1'b1;
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (inhibit && (r_state inside {ST_LOAD, ST_HIGH, ST_LOW})) begin
      w_state_nxt    = ST_GAP;
      w_cnt_nxt      = '0;
      w_bit_nxt      = '0;
      w_ps2_clk_nxt  = 1'b1;
      w_ps2_data_nxt = 1'b1;
      w_done_nxt     = 1'b0;
      w_held_nxt     = (r_state == ST_LOAD) ? w_src_byte : r_byte;
      w_held_vld_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_par      <= 1'b0;
      r_held     <= '0;
      r_held_vld <= 1'b0;
      r_ps2_clk  <= 1'b1;
      r_ps2_data <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit      <= w_bit_nxt;
      r_byte     <= w_byte_nxt;
      r_par      <= w_par_nxt;
      r_held     <= w_held_nxt;
      r_held_vld <= w_held_vld_nxt;
      r_ps2_clk  <= w_ps2_clk_nxt;
      r_ps2_data <= w_ps2_data_nxt;
      r_done     <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx: a line monitor decodes frames and compares
// them with a queue of accepted bytes turned into expected 11-bit frames.
module tb_ps2_kbd_tx;

  localparam int unsigned HALF = 4;
  localparam int unsigned GAP  = 20;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       inhibit = 1'b0;
  logic       in_ready, ps2_clk, ps2_data, busy, frame_done;

  always #5 clk = ~clk;

  ps2_kbd_tx #(.HALF(HALF), .GAP(GAP)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .inhibit    (inhibit),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: bytes accepted but not yet delivered by a completed frame.
  logic [7:0] exp_q[$];

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    int ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  int          cyc = 0;
  int          nbits = 0;
  int          n_frames = 0;
  int          n_falls = 0;
  int          hi_cnt = 0;
  int          t_start = 0;
  bit          seen = 1'b0;
  logic        prev_clk = 1'b1;
  logic        prev_data = 1'b1;
  logic [10:0] vec = '0;
  logic [10:0] last_frame = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (resetn) begin
      if (ps2_data !== prev_data) chk("data_chg_clk_hi", 32'(ps2_clk), 32'd1);
      if (prev_data && !ps2_data && ps2_clk && nbits == 0) begin
        if (seen) chk("idle_gap_ge_GAP", 32'(hi_cnt >= int'(GAP)), 32'd1);
        t_start = cyc;
      end
      if (prev_clk && !ps2_clk) begin
        n_falls++;
        if (nbits < 11) vec[nbits] = ps2_data;
        nbits++;
      end
      if (frame_done) begin
        logic [10:0] e;
        e = (exp_q.size() > 0) ? frame_of(exp_q[0]) : 11'h000;
        chk("done_after_11_bits", 32'(nbits), 32'd11);
        chk("frame_len_clks", 32'(cyc - t_start), 32'(22 * HALF));
        chk("frame_vs_model", 32'(vec), 32'(e));
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        last_frame = vec;
        n_frames++;
        seen = 1'b1;
      end
    end else begin
      seen = 1'b0;
    end
    hi_cnt = (ps2_clk && ps2_data) ? hi_cnt + 1 : 0;
    if (!busy) nbits = 0;
    prev_clk  = ps2_clk;
    prev_data = ps2_data;
  end

  task automatic push_byte(input logic [7:0] b);
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("push_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    exp_q.push_back(b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k = 0;
    while (n_frames < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_frames", 32'(n_frames >= target), 32'd1);
  endtask

  task automatic wait_falls(input int target, input int budget);
    int k = 0;
    while (n_falls < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_falls", 32'(n_falls >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    int f0, nf, pushed;

    repeat (3) @(negedge clk);
    chk("rst_ps2_clk", 32'(ps2_clk), 32'd1);
    chk("rst_ps2_data", 32'(ps2_data), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    resetn = 1'b1;

    f0 = n_frames;
    push_byte(8'h1C);
    wait_frames(f0 + 1, 2000);
    chk("frame_1C", 32'(last_frame), 32'(11'b1_0_00011100_0));

    f0 = n_frames;
    push_byte(8'h00);
    wait_frames(f0 + 1, 2000);
    chk("frame_00", 32'(last_frame), 32'(11'b1_1_00000000_0));

    f0 = n_frames;
    push_byte(8'hF0);
    wait_frames(f0 + 1, 2000);
    chk("frame_F0", 32'(last_frame), 32'(11'b1_1_11110000_0));

    f0 = n_frames;
    push_byte(8'hF0);
    push_byte(8'h1C);
    wait_frames(f0 + 2, 4000);
    chk("b2b_queue_drained", 32'(exp_q.size()), 32'd0);

    // Host holds the bus: four bytes fit, the fifth is refused, nothing moves.
    wait_idle(1000);
    @(negedge clk);
    inhibit = 1'b1;
    nf = n_falls;
    f0 = n_frames;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      chk("inh_in_ready", 32'(in_ready), 32'(i < 4));
      if (i < 4) exp_q.push_back(in_data);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("inh_full", 32'(in_ready), 32'd0);
    repeat (100) @(negedge clk);
    chk("inh_no_clk_edges", 32'(n_falls), 32'(nf));
    chk("inh_not_busy", 32'(busy), 32'd0);
    inhibit = 1'b0;
    wait_frames(f0 + 4, 6000);
    chk("inh_queue_drained", 32'(exp_q.size()), 32'd0);

    // Abort during bit 5 of 0x55, then expect a full retry.
    wait_idle(1000);
    f0 = n_frames;
    nf = n_falls;
    push_byte(8'h55);
    wait_falls(nf + 6, 2000);
    @(negedge clk);
    inhibit = 1'b1;
    @(negedge clk);
    inhibit = 1'b0;
    chk("abort_clk_high", 32'(ps2_clk), 32'd1);
    chk("abort_data_high", 32'(ps2_data), 32'd1);
    chk("abort_no_done", 32'(n_frames), 32'(f0));
    wait_frames(f0 + 1, 3000);
    chk("abort_resent_55", 32'(last_frame), 32'(11'b1_1_01010101_0));
    repeat (4 * HALF) @(negedge clk);
    chk("abort_single_done", 32'(n_frames), 32'(f0 + 1));

    // Reset in the middle of bit 3 with another byte queued behind it.
    wait_idle(1000);
    nf = n_falls;
    push_byte(8'hA5);
    push_byte(8'h3C);
    wait_falls(nf + 4, 2000);
    resetn = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_clk_high", 32'(ps2_clk), 32'd1);
    chk("midrst_data_high", 32'(ps2_data), 32'd1);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    nf = n_falls;
    repeat (300) @(negedge clk);
    chk("midrst_no_frames", 32'(n_falls), 32'(nf));
    chk("midrst_idle", 32'(busy), 32'd0);

    // Random traffic with occasional one-cycle host inhibits.
    f0 = n_frames;
    pushed = 0;
    for (int k = 0; k < 30000 && pushed < 20; k++) begin
      @(negedge clk);
      inhibit = ($urandom_range(0, 299) == 0);
      if (in_ready && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        exp_q.push_back(in_data);
        pushed++;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    inhibit  = 1'b0;
    wait_frames(f0 + pushed, 20000);
    chk("rand_pushed_all", 32'(pushed), 32'd20);
    chk("rand_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_tx.md
PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

Interface
REQ-001 SHALL have parameter HALF, default 50: system clocks per half ps2_clk period; legal range 2..1023.
REQ-002 SHALL have parameter GAP, default 200: minimum idle clocks (both lines high) between frames.
REQ-003 SHALL have port clk  in  1  system clock; all logic on posedge.
REQ-004 SHALL have port resetn  in  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  in  1  byte offered.
REQ-006 SHALL have port in_data  in  8  scan-code byte.
REQ-007 SHALL have port in_ready  out  1  FIFO can accept; equals not-full.
REQ-008 SHALL have port inhibit  in  1  host holding bus (clock low); already synchronised by the instantiator.
REQ-009 SHALL have port ps2_clk  out  1  device clock, idle high.
REQ-010 SHALL have port ps2_data  out  1  device data, idle high.
REQ-011 SHALL have port busy  out  1  frame in progress or GAP countdown running.
REQ-012 SHALL have port frame_done  out  1  one-cycle pulse after the stop bit's low phase ends.

Function
REQ-013 SHALL accept a byte when in_valid and in_ready are both high on a posedge; the byte enters a 4-entry FIFO.
REQ-014 SHALL provide a frame of 11 bits: start 0, data[0]..data[7] (LSB first), odd parity, stop 1.
REQ-015 SHALL make the parity bit equal ~^data, so the nine bits data+parity hold an odd count of ones.
REQ-016 SHALL, per bit, drive ps2_data to the bit value with ps2_clk high for HALF clocks, then ps2_clk low for HALF clocks with ps2_data held.
REQ-017 SHALL produce 22*HALF clocks per frame; bits change only while ps2_clk is high.
REQ-018 SHALL use FSM states IDLE, LOAD, HIGH, LOW, GAP.
REQ-019 SHALL go IDLE->LOAD when FIFO is non-empty and inhibit is low; LOAD pops the head into the shift register and precomputes parity.
REQ-020 SHALL go LOAD->HIGH; HIGH->LOW after HALF clocks; LOW->HIGH after HALF clocks if bit index < 10.
REQ-021 SHALL go LOW->GAP after bit 10, pulse frame_done, and drive both lines high in GAP.
REQ-022 SHALL go GAP->IDLE after GAP clocks.
REQ-023 SHALL abort on inhibit high in LOAD/HIGH/LOW: lines high next clock, go to GAP, no frame_done, and the aborted byte is retained and re-sent first.
REQ-024 SHALL not start a frame while inhibit is high in IDLE; FIFO keeps accepting.
REQ-025 SHALL allow push and pop in the same clock when full; occupancy stays unchanged and in_ready stays low that cycle.
REQ-026 SHALL make ps2_clk and ps2_data registered outputs.

Reset
REQ-027 SHALL, while resetn is low at a posedge, set FSM to IDLE, FIFO empty, ps2_clk=1, ps2_data=1, busy=0, frame_done=0, in_ready=1, and all counters to 0.
REQ-028 SHALL, on reset mid-frame, release both lines high on the next posedge and discard queued and in-flight bytes.

Structure
REQ-029 SHALL take from shared package ps2_pkg: FRAME_BITS=11, FIFO_DEPTH=4, the FSM state enum, and the odd-parity function, shared with the receiver.
REQ-030 SHALL have one sub-module ps2_tx_fifo: 4x8 synchronous FIFO with full/empty flags, 2-bit pointers plus a wrap bit.

Verification
REQ-031 SHALL cover: push 0x1C, HALF=4 -> falling-edge samples 0,0,0,1,1,1,0,0,0,0,1 (parity 0); frame_done 88 clocks after LOAD.
REQ-032 SHALL cover: push 0x00 -> parity bit 1; push 0xF0 -> data bits 0,0,0,0,1,1,1,1, parity 1.
REQ-033 SHALL cover: push 0xF0 then 0x1C back-to-back -> two frames in order, both lines high for >= GAP clocks between them.
REQ-034 SHALL cover: inhibit=1, push 5 bytes on consecutive cycles -> in_ready low after the 4th, 5th not stored, no ps2_clk edges; release -> 4 frames.
REQ-035 SHALL cover: inhibit pulse during bit 5 of 0x55 -> lines high next clock, no frame_done, after GAP a full 0x55 frame is re-sent.
REQ-036 SHALL cover: resetn low during bit 3 -> ps2_clk=ps2_data=1 next clock, FIFO empty, no further frames.
